// File: rtl/decoder_scan_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : decoder_scan_ctrl
// Description : Line sequencer for a 3-to-8 tri-state decoder. Scans the eight
//               lines in a loop, skipping masked lines, and inserts single-line
//               accesses requested over a req/ack handshake. The line code only
//               changes while the select is inactive, so decoder outputs never
//               glitch between lines.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module decoder_scan_ctrl #(
    parameter int DWELL = 4,   // cycles selbar is held low per line
    parameter int GAP   = 1,   // blanking cycles after each line
    parameter int CW    = 4    // dwell/gap counter width
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [0:7] mask,
    input  logic       req,
    input  logic [2:0] req_line,
    output logic       ack,
    output logic [0:2] dec,
    output logic       selbar,
    output logic [2:0] line_idx,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_setup  = 2'd1;
    localparam logic [1:0] c_st_active = 2'd2;
    localparam logic [1:0] c_st_gap    = 2'd3;

    localparam logic [CW-1:0] c_dwell_last  = CW'(DWELL - 1);
    localparam logic [CW-1:0] c_gap_last    = CW'(GAP - 1);
    localparam logic [CW-1:0] c_gap_prelast = CW'((GAP > 1) ? GAP - 2 : 0);
    localparam bit            c_gap_one     = (GAP == 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_ptr;      // next line the scan considers
    logic          r_is_req;   // current line is a request, not a scan line

    logic [2:0]    w_idx;
    logic          w_scan_found;
    logic [2:0]    w_scan_line;
    logic          w_none_above;
    logic          w_decide;
    logic          w_req_take;
    logic          w_enter_last_gap;

    // First unmasked line at or after the scan pointer, wrapping 7 -> 0
    always_comb begin
        w_scan_found = 1'b0;
        w_scan_line  = 3'd0;
        w_idx        = 3'd0;
        // Descending so the nearest hit is the last one written
        for (int k = 7; k >= 0; k--) begin
            w_idx = r_ptr + 3'(k);
            if (!mask[w_idx]) begin
                w_scan_found = 1'b1;
                w_scan_line  = w_idx;
            end
        end
    end

    // Frame wrap detection: no unmasked line above the current one
    always_comb begin
        w_none_above = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if ((3'(j) > line_idx) && !mask[3'(j)]) begin
                w_none_above = 1'b0;
            end
        end
    end

    // Decision point, request acceptance and last-GAP-cycle entry
    always_comb begin
        w_decide = (r_state == c_st_idle) ||
                   ((r_state == c_st_gap) && (r_cnt == c_gap_last));
        // The request being acked this cycle is still high; it is not new
        w_req_take = req && !ack;
        w_enter_last_gap = ((r_state == c_st_active) && (r_cnt == c_dwell_last) && c_gap_one) ||
                           ((r_state == c_st_gap) && !c_gap_one && (r_cnt == c_gap_prelast));
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_ptr      <= 3'd0;
            r_is_req   <= 1'b0;
            ack        <= 1'b0;
            dec        <= 3'b000;
            selbar     <= 1'b1;
            line_idx   <= 3'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            ack        <= 1'b0;
            frame_done <= 1'b0;
            if (w_enter_last_gap) begin
                ack        <= r_is_req;
                frame_done <= !r_is_req && w_none_above;
            end

            case (r_state)
                c_st_setup: begin
                    r_state <= c_st_active;
                    selbar  <= 1'b0;
                    r_cnt   <= '0;
                end
                c_st_active: begin
                    if (r_cnt == c_dwell_last) begin
                        r_state <= c_st_gap;
                        selbar  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin  // idle and gap
                    if (!w_decide) begin
                        r_cnt <= r_cnt + CW'(1);
                    end else if (w_req_take) begin
                        // Inserted access: scan pointer left untouched
                        r_state  <= c_st_setup;
                        line_idx <= req_line;
                        dec      <= ~req_line;   // 7 - i
                        r_is_req <= 1'b1;
                        busy     <= 1'b1;
                    end else if (en && w_scan_found) begin
                        r_state  <= c_st_setup;
                        line_idx <= w_scan_line;
                        dec      <= ~w_scan_line;
                        r_ptr    <= w_scan_line + 3'd1;
                        r_is_req <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        r_state  <= c_st_idle;
                        r_is_req <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_decoder_scan_ctrl
// Description : Self-checking bench for decoder_scan_ctrl. Expected lines are
//               queued when stimulus is driven and checked by a monitor as
//               each line's ACTIVE phase begins and ends.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_decoder_scan_ctrl;

    localparam int DWELL = 4;
    localparam int GAP   = 1;
    localparam int CW    = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [0:7] mask;
    logic       req;
    logic [2:0] req_line;
    logic       ack;
    logic [0:2] dec;
    logic       selbar;
    logic [2:0] line_idx;
    logic       busy;
    logic       frame_done;

    decoder_scan_ctrl #(.DWELL(DWELL), .GAP(GAP), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mask       (mask),
        .req        (req),
        .req_line   (req_line),
        .ack        (ack),
        .dec        (dec),
        .selbar     (selbar),
        .line_idx   (line_idx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] line;
        logic [2:0] dec;
        logic       is_req;
        logic       fd;
    } exp_t;

    typedef struct {
        logic [2:0] line;
        logic [2:0] dec;
    } req_vec_t;

    typedef struct {
        logic [7:0]  mask;
        int          n;
        logic [39:0] seq;   // nibble k = k-th expected line
        logic [9:0]  fd;    // bit k = frame_done expected on k-th line
    } scan_vec_t;

    exp_t      exp_q[$];
    int        n_checks = 0;
    int        n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_v, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Monitor: pop an expectation when selbar falls, check it when selbar rises
    exp_t cur;
    logic mon_valid = 1'b0;
    logic prev_sel  = 1'b1;
    int   low_cnt   = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_valid = 1'b0;
            prev_sel  = 1'b1;
        end else begin
            if (prev_sel && !selbar) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_line: line %0d dec %b at %0t", line_idx, dec, $time);
                    mon_valid = 1'b0;
                end else begin
                    cur = exp_q.pop_front();
                    mon_valid = 1'b1;
                    check("line_idx", 32'(line_idx), 32'(cur.line));
                    check("dec", 32'(dec), 32'(cur.dec));
                end
                low_cnt = 1;
            end else if (!selbar) begin
                low_cnt++;
            end else if (!prev_sel && selbar) begin
                check("dwell_len", 32'(low_cnt), 32'(DWELL));
                if (mon_valid) begin
                    check("ack", 32'(ack), 32'(cur.is_req));
                    check("frame_done", 32'(frame_done), 32'(cur.fd));
                end
                mon_valid = 1'b0;
            end else begin
                check("ack_quiet", 32'(ack), 32'd0);
                check("frame_done_quiet", 32'(frame_done), 32'd0);
            end
            prev_sel = selbar;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        @(negedge clk);
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy) timeout(name);
    endtask

    task automatic wait_q_empty(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            timeout(name);
            exp_q.delete();
        end
    endtask

    task automatic do_request(input logic [2:0] line, input logic [2:0] d);
        int t = 0;
        exp_t e;
        e.line = line; e.dec = d; e.is_req = 1'b1; e.fd = 1'b0;
        @(negedge clk);
        exp_q.push_back(e);
        req      = 1'b1;
        req_line = line;
        @(negedge clk);
        while (!ack && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ack) timeout("req_ack");
        // Drop req in the cycle after ack
        @(posedge clk);
        #1 req = 1'b0;
        wait_idle("req_idle");
    endtask

    req_vec_t  rv[5];
    scan_vec_t sv[4];
    exp_t      e;

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        req      = 1'b0;
        req_line = 3'd0;
        mask     = 8'h00;

        rv[0] = '{3'd2, 3'b101};
        rv[1] = '{3'd0, 3'b111};
        rv[2] = '{3'd7, 3'b000};
        rv[3] = '{3'd5, 3'b010};
        rv[4] = '{3'd3, 3'b100};

        sv[0] = '{8'b0000_0000, 9, 40'h0076543210, 10'h080};
        sv[1] = '{8'b1011_0110, 5, 40'h0000041741, 10'h004};
        sv[2] = '{8'b0111_1111, 3, 40'h0000000000, 10'h007};
        sv[3] = '{8'b1111_1110, 2, 40'h0000000077, 10'h003};

        // Reset values while held and for 20 idle cycles after release
        repeat (3) @(negedge clk);
        check("rst_selbar", 32'(selbar), 32'd1);
        check("rst_dec", 32'(dec), 32'd0);
        check("rst_line_idx", 32'(line_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle_selbar", 32'(selbar), 32'd1);
            check("idle_dec", 32'(dec), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end

        // Single request, cycle-exact: line 2 sampled at edge 0
        e.line = 3'd2; e.dec = 3'b101; e.is_req = 1'b1; e.fd = 1'b0;
        exp_q.push_back(e);
        req      = 1'b1;
        req_line = 3'd2;
        @(posedge clk);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            check("seq_selbar", 32'(selbar), (c >= 2 && c <= 5) ? 32'd0 : 32'd1);
            check("seq_ack", 32'(ack), (c == 6) ? 32'd1 : 32'd0);
            check("seq_busy", 32'(busy), (c <= 6) ? 32'd1 : 32'd0);
            if (c == 1) begin
                check("seq_dec", 32'(dec), 32'b101);
                check("seq_line_idx", 32'(line_idx), 32'd2);
            end
            if (c == 6) begin
                @(posedge clk);
                #1 req = 1'b0;
            end
        end

        // Request table
        for (int i = 0; i < 5; i++) do_request(rv[i].line, rv[i].dec);

        // Scan table: each starts from reset so the scan pointer is 0
        for (int i = 0; i < 4; i++) begin
            do_reset();
            mask = sv[i].mask;
            for (int k = 0; k < sv[i].n; k++) begin
                e.line   = sv[i].seq[4*k +: 3];
                e.dec    = 3'(7 - int'(e.line));
                e.is_req = 1'b0;
                e.fd     = sv[i].fd[k];
                exp_q.push_back(e);
            end
            @(negedge clk);
            en = 1'b1;
            wait_q_empty("scan_lines");
            en = 1'b0;
            wait_idle("scan_idle");
        end

        // Request inserted during line 3 of a full scan
        do_reset();
        mask = 8'h00;
        for (int k = 0; k < 4; k++) begin
            e.line = 3'(k); e.dec = 3'(7 - k); e.is_req = 1'b0; e.fd = 1'b0;
            exp_q.push_back(e);
        end
        @(negedge clk);
        en = 1'b1;
        begin
            int t = 0;
            while (!(line_idx == 3'd3 && !selbar) && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!(line_idx == 3'd3 && !selbar)) timeout("midscan_line3");
        end
        req      = 1'b1;
        req_line = 3'd5;
        e.line = 3'd5; e.dec = 3'b010; e.is_req = 1'b1; e.fd = 1'b0;
        exp_q.push_back(e);
        e.line = 3'd4; e.dec = 3'b011; e.is_req = 1'b0; e.fd = 1'b0;
        exp_q.push_back(e);
        begin
            int t = 0;
            while (!ack && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!ack) timeout("midscan_ack");
        end
        @(posedge clk);
        #1 req = 1'b0;
        wait_q_empty("midscan_lines");
        en = 1'b0;
        wait_idle("midscan_idle");

        // All lines masked: no scan, requests still served
        do_reset();
        mask = 8'hFF;
        en   = 1'b1;
        repeat (30) @(negedge clk);
        check("allmask_busy", 32'(busy), 32'd0);
        check("allmask_selbar", 32'(selbar), 32'd1);
        do_request(3'd6, 3'b001);
        en = 1'b0;

        // Asynchronous reset while selbar is low drops the request
        do_reset();
        mask = 8'h00;
        e.line = 3'd1; e.dec = 3'b110; e.is_req = 1'b1; e.fd = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        req      = 1'b1;
        req_line = 3'd1;
        begin
            int t = 0;
            @(negedge clk);
            while (selbar && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (selbar) timeout("areset_active");
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("areset_selbar", 32'(selbar), 32'd1);
        check("areset_busy", 32'(busy), 32'd0);
        req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            logic seen_ack = 1'b0;
            logic seen_busy = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                seen_ack  = seen_ack | ack;
                seen_busy = seen_busy | busy;
            end
            check("areset_no_ack", 32'(seen_ack), 32'd0);
            check("areset_no_busy", 32'(seen_busy), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
